// File: rtl/id_counter_dco.sv
// rtl/id_counter_dco.sv - DPLL increment/decrement counter and DCO with divide-by-N recovered clock
module id_counter_dco #(
  parameter int ID_MOD_W = 2,
  parameter int PEND_W   = 3,
  parameter int NDIV_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              carry,
  input  logic              borrow,
  input  logic [NDIV_W-1:0] nDiv,
  output logic              idOut,
  output logic              fOut,
  output logic              adv,
  output logic              ret,
  output logic              ovf
);

  localparam logic [ID_MOD_W-1:0]    PH_LAST  = '1;
  localparam logic signed [PEND_W+1:0] PEND_MAX = (PEND_W+2)'((1 << (PEND_W-1)) - 1);
  localparam logic signed [PEND_W+1:0] PEND_MIN = -PEND_MAX;

  logic [ID_MOD_W-1:0]      ph_q, ph_d;
  logic signed [PEND_W-1:0] pend_q, pend_d;
  logic                     held_q, held_d;
  logic [NDIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic                     fout_q, fout_d;
  logic                     adv_q, adv_d;
  logic                     ret_q, ret_d;
  logic                     ovf_q, ovf_d;

  logic                     corr_pt;
  logic                     rise;
  logic signed [PEND_W+1:0] net;
  logic signed [PEND_W+1:0] pend_raw;

  always_comb begin
    net = '0;
    if (enable && carry && !borrow) net = (PEND_W+2)'(1);
    else if (enable && borrow && !carry) net = '1;

    // held_q marks the extra clk of a retard so the repeated M-1 is not a second correction point
    corr_pt = enable && !held_q && (ph_q == PH_LAST);
    adv_d   = corr_pt && !pend_q[PEND_W-1] && (pend_q != '0);
    ret_d   = corr_pt && pend_q[PEND_W-1];
    held_d  = ret_d;

    ph_d = ph_q + ID_MOD_W'(1);
    if (adv_d) ph_d = ID_MOD_W'(1);
    else if (ret_d) ph_d = ph_q;

    pend_raw = {{2{pend_q[PEND_W-1]}}, pend_q} + net;
    if (adv_d) pend_raw = pend_raw - (PEND_W+2)'(1);
    else if (ret_d) pend_raw = pend_raw + (PEND_W+2)'(1);

    pend_d = pend_raw[PEND_W-1:0];
    ovf_d  = 1'b0;
    if (!enable) begin
      pend_d = '0;
    end else if (pend_raw > PEND_MAX) begin
      pend_d = PEND_MAX[PEND_W-1:0];
      ovf_d  = 1'b1;
    end else if (pend_raw < PEND_MIN) begin
      pend_d = PEND_MIN[PEND_W-1:0];
      ovf_d  = 1'b1;
    end

    rise      = !ph_q[ID_MOD_W-1] && ph_d[ID_MOD_W-1];
    div_cnt_d = div_cnt_q;
    fout_d    = ph_d[ID_MOD_W-1];
    if (nDiv < NDIV_W'(2)) begin
      div_cnt_d = '0;
    end else begin
      // the >= compare also recovers a count left out of range by an nDiv change
      if (rise) div_cnt_d = (div_cnt_q >= nDiv - NDIV_W'(1)) ? '0 : div_cnt_q + NDIV_W'(1);
      fout_d = (div_cnt_d < (nDiv >> 1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_q      <= '0;
      pend_q    <= '0;
      held_q    <= 1'b0;
      div_cnt_q <= '0;
      fout_q    <= 1'b0;
      adv_q     <= 1'b0;
      ret_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ph_q      <= ph_d;
      pend_q    <= pend_d;
      held_q    <= held_d;
      div_cnt_q <= div_cnt_d;
      fout_q    <= fout_d;
      adv_q     <= adv_d;
      ret_q     <= ret_d;
      ovf_q     <= ovf_d;
    end
  end

  assign idOut = ph_q[ID_MOD_W-1];
  assign fOut  = fout_q;
  assign adv   = adv_q;
  assign ret   = ret_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_id_counter_dco.sv
// tb/tb_id_counter_dco.sv - scoreboard bench for the DPLL ID counter / DCO
module tb_id_counter_dco;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       carry = 1'b0;
  logic       borrow = 1'b0;
  logic [7:0] nDiv = 8'd4;
  logic       idOut, fOut, adv, ret, ovf;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int per_q[$];
  int fper_q[$];
  int fhigh_q[$];
  int exp_q[$];
  int last_rise = -1;
  int first_rise = -1;
  int f_rise = -1;
  int adv_cnt = 0;
  int ret_cnt = 0;
  int ovf_cnt = 0;
  logic prev_id = 1'b0;
  logic prev_f = 1'b0;

  id_counter_dco #(.ID_MOD_W(2), .PEND_W(3), .NDIV_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .carry(carry), .borrow(borrow),
    .nDiv(nDiv), .idOut(idOut), .fOut(fOut), .adv(adv), .ret(ret), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) edge_n <= 0;
    else edge_n <= edge_n + 1;
  end

  // Output monitor on the falling edge: records idOut/fOut intervals in edges and strobe counts
  always @(negedge clk) begin
    if (!reset) begin
      last_rise = -1;
      first_rise = -1;
      f_rise = -1;
    end else begin
      if (idOut && !prev_id) begin
        if (last_rise >= 0) per_q.push_back(edge_n - last_rise);
        if (first_rise < 0) first_rise = edge_n;
        last_rise = edge_n;
      end
      if (fOut && !prev_f) begin
        if (f_rise >= 0) fper_q.push_back(edge_n - f_rise);
        f_rise = edge_n;
      end
      if (!fOut && prev_f && f_rise >= 0) fhigh_q.push_back(edge_n - f_rise);
      if (adv) adv_cnt++;
      if (ret) ret_cnt++;
      if (ovf) ovf_cnt++;
    end
    prev_id = idOut;
    prev_f = fOut;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic c);
    reset = 1'b0;
    enable = 1'b1;
    carry = c;
    borrow = 1'b0;
    tick(2);
    adv_cnt = 0; ret_cnt = 0; ovf_cnt = 0;
    per_q.delete(); fper_q.delete(); fhigh_q.delete(); exp_q.delete();
    reset = 1'b1;
  endtask

  task automatic wait_rise(output bit ok);
    logic p;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      p = idOut;
      tick(1);
      if (!p && idOut) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_periods(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (per_q.size() >= exp_q.size()) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic clear_window();
    per_q.delete();
    exp_q.delete();
    last_rise = -1;
    adv_cnt = 0; ret_cnt = 0; ovf_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(2);
    checks++; if (idOut !== 1'b0) begin failures++; $display("FAIL reset_idOut got=%b exp=0", idOut); end
    checks++; if (fOut !== 1'b0) begin failures++; $display("FAIL reset_fOut got=%b exp=0", fOut); end
    checks++; if ({adv, ret, ovf} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {adv, ret, ovf}); end
  endtask

  task automatic test_free_run();
    bit ok;
    int e, o;
    nDiv = 8'd4;
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) exp_q.push_back(4);
    wait_periods(ok);
    checks++; if (!ok) begin failures++; $display("FAIL free_run_timeout got=%0d exp=%0d periods", per_q.size(), exp_q.size()); end
    checks++; if (first_rise !== 2) begin failures++; $display("FAIL free_run_first_rise got=%0d exp=2", first_rise); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (per_q.size() > 0) ? per_q.pop_front() : -1;
      checks++; if (o !== e) begin failures++; $display("FAIL free_run_period got=%0d exp=%0d", o, e); end
    end
    fper_q.delete(); fhigh_q.delete(); f_rise = -1;
    tick(50);
    o = (fper_q.size() > 0) ? fper_q[0] : -1;
    checks++; if (o !== 16) begin failures++; $display("FAIL free_run_fOut_period got=%0d exp=16", o); end
    o = (fhigh_q.size() > 0) ? fhigh_q[0] : -1;
    checks++; if (o !== 8) begin failures++; $display("FAIL free_run_fOut_high got=%0d exp=8", o); end
  endtask

  task automatic test_single(input logic c, input logic b, input int ncyc, input string name,
                             input int exp_first, input int exp_adv, input int exp_ret);
    bit ok;
    int e, o;
    wait_rise(ok);
    checks++; if (!ok) begin failures++; $display("FAIL %s_rise_timeout got=0 exp=1", name); end
    clear_window();
    carry = c;
    borrow = b;
    exp_q.push_back(exp_first);
    for (int i = 0; i < 3; i++) exp_q.push_back(4);
    tick(ncyc);
    carry = 1'b0;
    borrow = 1'b0;
    wait_periods(ok);
    checks++; if (!ok) begin failures++; $display("FAIL %s_timeout got=%0d exp=%0d periods", name, per_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (per_q.size() > 0) ? per_q.pop_front() : -1;
      checks++; if (o !== e) begin failures++; $display("FAIL %s_period got=%0d exp=%0d", name, o, e); end
    end
    checks++; if (adv_cnt !== exp_adv) begin failures++; $display("FAIL %s_adv_count got=%0d exp=%0d", name, adv_cnt, exp_adv); end
    checks++; if (ret_cnt !== exp_ret) begin failures++; $display("FAIL %s_ret_count got=%0d exp=%0d", name, ret_cnt, exp_ret); end
  endtask

  task automatic test_saturation();
    bit ok;
    int e, o;
    int exp_per[7] = '{3, 3, 3, 3, 3, 4, 4};
    do_reset(1'b1);
    foreach (exp_per[i]) exp_q.push_back(exp_per[i]);
    tick(8);
    carry = 1'b0;
    wait_periods(ok);
    checks++; if (!ok) begin failures++; $display("FAIL sat_timeout got=%0d exp=%0d periods", per_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (per_q.size() > 0) ? per_q.pop_front() : -1;
      checks++; if (o !== e) begin failures++; $display("FAIL sat_period got=%0d exp=%0d", o, e); end
    end
    checks++; if (ovf_cnt < 1) begin failures++; $display("FAIL sat_ovf_count got=%0d exp>=1", ovf_cnt); end
    checks++; if (adv_cnt !== 5) begin failures++; $display("FAIL sat_adv_count got=%0d exp=5", adv_cnt); end
  endtask

  task automatic test_enable_clear();
    bit ok;
    int e, o;
    wait_rise(ok);
    checks++; if (!ok) begin failures++; $display("FAIL enable_rise_timeout got=0 exp=1"); end
    clear_window();
    for (int i = 0; i < 4; i++) exp_q.push_back(4);
    tick(1);
    carry = 1'b1;
    tick(2);
    carry = 1'b0;
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    wait_periods(ok);
    checks++; if (!ok) begin failures++; $display("FAIL enable_timeout got=%0d exp=%0d periods", per_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (per_q.size() > 0) ? per_q.pop_front() : -1;
      checks++; if (o !== e) begin failures++; $display("FAIL enable_period got=%0d exp=%0d", o, e); end
    end
    checks++; if (adv_cnt !== 0) begin failures++; $display("FAIL enable_adv_count got=%0d exp=0", adv_cnt); end
  endtask

  task automatic test_async_reset();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (idOut && fOut) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    checks++; if (!ok) begin failures++; $display("FAIL async_wait_high got=0 exp=1"); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (idOut !== 1'b0) begin failures++; $display("FAIL async_idOut got=%b exp=0", idOut); end
    checks++; if (fOut !== 1'b0) begin failures++; $display("FAIL async_fOut got=%b exp=0", fOut); end
  endtask

  task automatic test_bypass();
    nDiv = 8'd1;
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      checks++; if (fOut !== idOut) begin failures++; $display("FAIL bypass1_fOut got=%b exp=%b", fOut, idOut); end
    end
    nDiv = 8'd0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      checks++; if (fOut !== idOut) begin failures++; $display("FAIL bypass0_fOut got=%b exp=%b", fOut, idOut); end
    end
    nDiv = 8'd4;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_single(1'b1, 1'b0, 1, "carry", 3, 1, 0);
    test_single(1'b0, 1'b1, 1, "borrow", 5, 0, 1);
    test_single(1'b1, 1'b1, 3, "cancel", 4, 0, 0);
    test_saturation();
    test_enable_clear();
    test_async_reset();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
